// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf - two-entry skid buffer used as a pipeline-stage register.
//
// Sits between two pipeline stages (IF->ID, ID->EX, ...). A main register drives the
// output and a skid register absorbs the one entry that can arrive while the output is
// blocked. Because of the skid entry, in_ready_o depends only on state flops, so there
// is no combinational path from out_ready_i / stall_i back to in_ready_o.
//
// Parameters:
//   DATA_W      payload width in bits
//   BUBBLE_VAL  payload held in an empty entry; driven on out_data_o when out_valid_o=0
//   CNT_W       performance counter width
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   flush_i      synchronous flush, discards held and incoming entries (highest priority)
//   stall_i      hazard stall, blocks output transfer this cycle
//   in_valid_i   upstream entry valid
//   in_ready_o   buffer can accept an entry (registered state only)
//   in_data_i    upstream payload
//   out_valid_o  main entry valid
//   out_ready_i  downstream accepts
//   out_data_o   main entry payload
//   occupancy_o  entries held, 0..2
//   stall_cnt_o  cycles with a valid output that did not transfer (flush cycles excluded)
//   drop_cnt_o   entries discarded by flush
//
// Build option:
//   PIPE_SKID_BUF_PERF_EN  when defined, builds the saturating stall/drop counters;
//                          otherwise both counter ports are tied to zero.

module pipe_skid_buf #(
  parameter int unsigned       DATA_W     = 96,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter int unsigned       CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  drop_cnt_o
);

  // State encoding equals the number of held entries.
  localparam logic [1:0] StEmpty = 2'd0;
  localparam logic [1:0] StOne   = 2'd1;
  localparam logic [1:0] StTwo   = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] w_main_nxt;
  logic [DATA_W-1:0] r_skid;
  logic [DATA_W-1:0] w_skid_nxt;
  logic              w_in_fire;
  logic              w_out_fire;

  // ---------------------------------------------------------------------------
  // Handshake outputs, all from state flops
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready_o  = (r_state != StTwo);
    out_valid_o = (r_state != StEmpty);
    out_data_o  = r_main;
    unique case (r_state)
      StOne:   occupancy_o = 2'd1;
      StTwo:   occupancy_o = 2'd2;
      default: occupancy_o = 2'd0;
    endcase
  end

  assign w_in_fire  = in_valid_i & in_ready_o;
  assign w_out_fire = out_valid_o & out_ready_i & ~stall_i;

  // ---------------------------------------------------------------------------
  // Next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;

    if (flush_i) begin
      // Flush beats everything; an accepted input this cycle is dropped.
      w_state_nxt = StEmpty;
      w_main_nxt  = BUBBLE_VAL;
      w_skid_nxt  = BUBBLE_VAL;
    end else begin
      case (r_state)
        StEmpty: begin
          if (w_in_fire) begin
            w_state_nxt = StOne;
            w_main_nxt  = in_data_i;
          end
        end

        StOne: begin
          if (w_in_fire && w_out_fire) begin
            w_main_nxt = in_data_i;
          end else if (w_in_fire) begin
            w_state_nxt = StTwo;
            w_skid_nxt  = in_data_i;
          end else if (w_out_fire) begin
            w_state_nxt = StEmpty;
            w_main_nxt  = BUBBLE_VAL;
          end
        end

        StTwo: begin
          // in_ready_o is low here, so only the drain path exists.
          if (w_out_fire) begin
            w_state_nxt = StOne;
            w_main_nxt  = r_skid;
            w_skid_nxt  = BUBBLE_VAL;
          end
        end

        default: begin
          // Unreachable encoding: recover to a clean empty buffer.
          w_state_nxt = StEmpty;
          w_main_nxt  = BUBBLE_VAL;
          w_skid_nxt  = BUBBLE_VAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StEmpty;
      r_main  <= BUBBLE_VAL;
      r_skid  <= BUBBLE_VAL;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef PIPE_SKID_BUF_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_drop_cnt;
  logic [CNT_W-1:0] w_stall_cnt_nxt;
  logic [CNT_W-1:0] w_drop_cnt_nxt;
  logic [2:0]       w_drop_amt;
  logic [CNT_W:0]   w_drop_sum;
  logic             w_stall_evt;

  // Entries lost to a flush: everything held plus an accepted input, minus one that
  // still reached downstream. out_fire implies occupancy >= 1, so this never underflows.
  assign w_drop_amt  = 3'(occupancy_o) + 3'(w_in_fire) - 3'(w_out_fire);
  assign w_drop_sum  = {1'b0, r_drop_cnt} + (CNT_W+1)'(w_drop_amt);
  assign w_stall_evt = out_valid_o & ~w_out_fire & ~flush_i;

  always_comb begin
    w_stall_cnt_nxt = r_stall_cnt;
    w_drop_cnt_nxt  = r_drop_cnt;
    if (w_stall_evt && (r_stall_cnt != {CNT_W{1'b1}})) begin
      w_stall_cnt_nxt = r_stall_cnt + 1'b1;
    end
    if (flush_i) begin
      w_drop_cnt_nxt = w_drop_sum[CNT_W] ? {CNT_W{1'b1}} : w_drop_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_stall_cnt <= w_stall_cnt_nxt;
      r_drop_cnt  <= w_drop_cnt_nxt;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign drop_cnt_o  = r_drop_cnt;
`else
  assign stall_cnt_o = '0;
  assign drop_cnt_o  = '0;
`endif

  // ---------------------------------------------------------------------------
  // Simulation-only invariants
  // ---------------------------------------------------------------------------
`ifndef SYNTHESIS
  a_state_legal : assert property (@(posedge clk) disable iff (!rst_n)
    r_state != 2'd3);

  a_empty_is_bubble : assert property (@(posedge clk) disable iff (!rst_n)
    !out_valid_o |-> (out_data_o == BUBBLE_VAL));

  // A blocked, unflushed output entry stays put.
  a_payload_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid_o && !w_out_fire && !flush_i) |=> (out_valid_o && $stable(out_data_o)));
`endif

endmodule

// File: tb/tb_pipe_skid_buf.sv
module tb_pipe_skid_buf;

`ifdef PIPE_SKID_BUF_PERF_EN
  localparam bit Perf = 1'b1;
`else
  localparam bit Perf = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        flush_i;
  logic        stall_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [95:0] in_data_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [95:0] out_data_o;
  logic [1:0]  occupancy_o;
  logic [15:0] stall_cnt_o;
  logic [15:0] drop_cnt_o;

  int n_vec;
  int n_err;

  pipe_skid_buf dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .stall_i     (stall_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .occupancy_o (occupancy_o),
    .stall_cnt_o (stall_cnt_o),
    .drop_cnt_o  (drop_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    flush_i     = 1'b0;
    stall_i     = 1'b0;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    out_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    n_vec++;
    if (out_valid_o !== 1'b0) begin
      $display("FAIL reset_valid: got %b want 0", out_valid_o); n_err++;
    end
    n_vec++;
    if (out_data_o !== 96'h0) begin
      $display("FAIL reset_data: got %h want 0", out_data_o); n_err++;
    end
    n_vec++;
    if (in_ready_o !== 1'b1) begin
      $display("FAIL reset_ready: got %b want 1", in_ready_o); n_err++;
    end
    n_vec++;
    if (occupancy_o !== 2'd0) begin
      $display("FAIL reset_occ: got %0d want 0", occupancy_o); n_err++;
    end
    n_vec++;
    if ({stall_cnt_o, drop_cnt_o} !== 32'h0) begin
      $display("FAIL reset_cnt: got %h/%h want 0/0", stall_cnt_o, drop_cnt_o); n_err++;
    end
  endtask

  task automatic test_streaming();
    logic [95:0] vals [3];
    vals[0] = 96'h1; vals[1] = 96'h2; vals[2] = 96'h3;
    do_reset();
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data_i = vals[i];
      tick();
      n_vec++;
      if (out_valid_o !== 1'b1 || out_data_o !== vals[i]) begin
        $display("FAIL stream_out%0d: got v=%b d=%h want v=1 d=%h",
                 i, out_valid_o, out_data_o, vals[i]);
        n_err++;
      end
      n_vec++;
      if (occupancy_o !== 2'd1 || in_ready_o !== 1'b1) begin
        $display("FAIL stream_occ%0d: got occ=%0d rdy=%b want occ=1 rdy=1",
                 i, occupancy_o, in_ready_o);
        n_err++;
      end
    end
    in_valid_i = 1'b0;
    tick();
    n_vec++;
    if (occupancy_o !== 2'd0 || out_valid_o !== 1'b0 || out_data_o !== 96'h0) begin
      $display("FAIL stream_drain: got occ=%0d v=%b d=%h want 0/0/0",
               occupancy_o, out_valid_o, out_data_o);
      n_err++;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    in_data_i   = 96'hA;
    tick();
    in_data_i = 96'hB;
    tick();
    n_vec++;
    if (occupancy_o !== 2'd2 || in_ready_o !== 1'b0 || out_data_o !== 96'hA) begin
      $display("FAIL bp_full: got occ=%0d rdy=%b d=%h want occ=2 rdy=0 d=a",
               occupancy_o, in_ready_o, out_data_o);
      n_err++;
    end
    in_data_i = 96'hC;
    tick();
    n_vec++;
    if (occupancy_o !== 2'd2 || in_ready_o !== 1'b0 || out_data_o !== 96'hA) begin
      $display("FAIL bp_hold: got occ=%0d rdy=%b d=%h want occ=2 rdy=0 d=a",
               occupancy_o, in_ready_o, out_data_o);
      n_err++;
    end
    // 0xC stays offered; it is accepted only once in_ready_o returns.
    out_ready_i = 1'b1;
    tick();
    n_vec++;
    if (out_data_o !== 96'hB || occupancy_o !== 2'd1 || in_ready_o !== 1'b1) begin
      $display("FAIL bp_second: got d=%h occ=%0d rdy=%b want d=b occ=1 rdy=1",
               out_data_o, occupancy_o, in_ready_o);
      n_err++;
    end
    tick();
    n_vec++;
    if (out_data_o !== 96'hC || occupancy_o !== 2'd1) begin
      $display("FAIL bp_third: got d=%h occ=%0d want d=c occ=1", out_data_o, occupancy_o);
      n_err++;
    end
    in_valid_i = 1'b0;
    tick();
    n_vec++;
    if (occupancy_o !== 2'd0 || out_valid_o !== 1'b0) begin
      $display("FAIL bp_empty: got occ=%0d v=%b want 0/0", occupancy_o, out_valid_o);
      n_err++;
    end
  endtask

  task automatic test_stall();
    do_reset();
    in_valid_i = 1'b1;
    in_data_i  = 96'h5;
    tick();
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    stall_i     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (out_valid_o !== 1'b1 || out_data_o !== 96'h5 || occupancy_o !== 2'd1) begin
        $display("FAIL stall_hold%0d: got v=%b d=%h occ=%0d want v=1 d=5 occ=1",
                 i, out_valid_o, out_data_o, occupancy_o);
        n_err++;
      end
    end
    n_vec++;
    if (stall_cnt_o !== (Perf ? 16'd3 : 16'd0)) begin
      $display("FAIL stall_cnt: got %0d want %0d", stall_cnt_o, Perf ? 3 : 0);
      n_err++;
    end
    stall_i = 1'b0;
    tick();
    n_vec++;
    if (out_valid_o !== 1'b0 || occupancy_o !== 2'd0) begin
      $display("FAIL stall_release: got v=%b occ=%0d want v=0 occ=0", out_valid_o, occupancy_o);
      n_err++;
    end
  endtask

  task automatic test_flush();
    do_reset();
    in_valid_i = 1'b1;
    in_data_i  = 96'h7;
    tick();
    in_data_i = 96'h8;
    tick();
    in_data_i = 96'h9;
    flush_i   = 1'b1;
    tick();
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    n_vec++;
    if (occupancy_o !== 2'd0 || out_valid_o !== 1'b0 || out_data_o !== 96'h0 ||
        in_ready_o !== 1'b1) begin
      $display("FAIL flush_two: got occ=%0d v=%b d=%h rdy=%b want 0/0/0/1",
               occupancy_o, out_valid_o, out_data_o, in_ready_o);
      n_err++;
    end
    n_vec++;
    if (drop_cnt_o !== (Perf ? 16'd2 : 16'd0)) begin
      $display("FAIL flush_drop: got %0d want %0d", drop_cnt_o, Perf ? 2 : 0);
      n_err++;
    end
    n_vec++;
    if (stall_cnt_o !== (Perf ? 16'd1 : 16'd0)) begin
      $display("FAIL flush_stallcnt: got %0d want %0d", stall_cnt_o, Perf ? 1 : 0);
      n_err++;
    end
  endtask

  task automatic test_flush_stall_reset();
    do_reset();
    in_valid_i = 1'b1;
    in_data_i  = 96'h4;
    tick();
    // ONE holding 0x4; flush and stall together, with a new entry offered.
    in_data_i   = 96'h6;
    out_ready_i = 1'b1;
    flush_i     = 1'b1;
    stall_i     = 1'b1;
    tick();
    flush_i     = 1'b0;
    stall_i     = 1'b0;
    out_ready_i = 1'b0;
    n_vec++;
    if (occupancy_o !== 2'd0 || out_valid_o !== 1'b0 || out_data_o !== 96'h0) begin
      $display("FAIL fs_empty: got occ=%0d v=%b d=%h want 0/0/0",
               occupancy_o, out_valid_o, out_data_o);
      n_err++;
    end
    n_vec++;
    if (drop_cnt_o !== (Perf ? 16'd2 : 16'd0)) begin
      $display("FAIL fs_drop: got %0d want %0d", drop_cnt_o, Perf ? 2 : 0);
      n_err++;
    end
    in_data_i = 96'h11;
    tick();
    in_data_i = 96'h22;
    tick();
    in_valid_i = 1'b0;
    n_vec++;
    if (occupancy_o !== 2'd2 || out_data_o !== 96'h11) begin
      $display("FAIL fs_refill: got occ=%0d d=%h want occ=2 d=11", occupancy_o, out_data_o);
      n_err++;
    end
    // Mid-cycle asynchronous reset, checked before the next rising edge.
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (occupancy_o !== 2'd0 || out_valid_o !== 1'b0 || out_data_o !== 96'h0 ||
        in_ready_o !== 1'b1 || {stall_cnt_o, drop_cnt_o} !== 32'h0) begin
      $display("FAIL async_reset: got occ=%0d v=%b d=%h rdy=%b cnt=%h/%h want 0/0/0/1/0/0",
               occupancy_o, out_valid_o, out_data_o, in_ready_o, stall_cnt_o, drop_cnt_o);
      n_err++;
    end
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_stall();
    test_flush();
    test_flush_stall_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
